// File: rtl/ram_stream_loader.sv
// Byte-stream to 32-bit word loader for an Avalon-MM on-chip RAM slave.
// Packs bytes little-endian, writes one word per WRITE state, flags overflow at the RAM top.
module ram_stream_loader #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DEPTH      = 10240
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           byte_count,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [3:0]            byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [31:0]           writedata,
  output logic                  clken,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           rem_q, rem_d;
  logic [1:0]            lane_q, lane_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  hs;
  logic                  base_oob;

  assign hs       = in_valid && (state_q == COLLECT);
  assign base_oob = 32'(base_addr) >= DEPTH;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      be_q    <= be_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (byte_count == 16'd0) state_d = FINISH;
          else if (base_oob)       state_d = FINISH;
          else                     state_d = COLLECT;
        end
      end
      COLLECT: begin
        // Leave on the handshake that fills lane 3 or consumes the last byte.
        if (hs && (lane_q == 2'd3 || rem_q == 16'd1)) state_d = WRITE;
      end
      WRITE: begin
        if (rem_q == 16'd0 || addr_q == LAST_ADDR) state_d = FINISH;
        else                                      state_d = COLLECT;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    lane_d = lane_q;
    be_d   = be_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    wr_d   = (state_d == WRITE);
    busy_d = (state_d == COLLECT) || (state_d == WRITE);
    done_d = (state_d == FINISH);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = byte_count;
          lane_d = '0;
          be_d   = '0;
          data_d = '0;
          ovf_d  = (byte_count != 16'd0) && base_oob;
        end
      end
      COLLECT: begin
        if (hs) begin
          data_d[{lane_q, 3'b000} +: 8] = in_data;
          be_d[lane_q]                  = 1'b1;
          lane_d                        = lane_q + 2'd1;
          rem_d                         = rem_q - 16'd1;
        end
      end
      WRITE: begin
        if (rem_q != 16'd0) begin
          if (addr_q == LAST_ADDR) begin
            ovf_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            lane_d = '0;
            be_d   = '0;
            data_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign in_ready   = (state_q == COLLECT);
  assign address    = addr_q;
  assign byteenable = be_q;
  assign writedata  = data_q;
  assign chipselect = wr_q;
  assign write      = wr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign clken      = 1'b1;

endmodule

// File: tb/tb_ram_stream_loader.sv
// Self-checking bench for ram_stream_loader: transfer table plus backpressure and reset sequences.
module tb_ram_stream_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [13:0] base_addr;
  logic [15:0] byte_count;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic        busy;
  logic        done;
  logic        overflow;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [13:0] base;
    logic [15:0] cnt;
    logic [7:0]  b0;
    int unsigned nw;
    logic [13:0] a0;
    logic [31:0] d0;
    logic [3:0]  e0;
    logic [13:0] a1;
    logic [31:0] d1;
    logic [3:0]  e1;
    logic        ovf;
    int unsigned nacc;
  } vec_t;

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0]  e;
  } wr_t;

  wr_t  sb[$];
  vec_t vecs[7];
  vec_t vrst;

  ram_stream_loader #(.ADDR_WIDTH(14), .DEPTH(10240)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .byte_count (byte_count),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .address    (address),
    .byteenable (byteenable),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .clken      (clken),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input bit rnd, input bit pulse);
    int unsigned acc = 0;
    int unsigned last_wr = 0;
    int unsigned done_cyc = 0;
    bit got_done = 1'b0;
    wr_t exp_w;
    if (v.nw > 0) sb.push_back('{v.a0, v.d0, v.e0});
    if (v.nw > 1) sb.push_back('{v.a1, v.d1, v.e1});
    @(negedge clk);
    start      = 1'b1;
    base_addr  = v.base;
    byte_count = v.cnt;
    in_valid   = 1'b0;
    for (int unsigned c = 1; c <= 300 && !got_done; c++) begin
      @(negedge clk);
      start = pulse && (c == 3 || c == 7);
      if (start) begin
        base_addr  = 14'h3000;
        byte_count = 16'd0;
      end
      if (c == 1) begin
        chk("busy_c1", 64'(busy), 64'(v.cnt != 0 && v.base < 14'd10240));
        chk("ovf_c1", 64'(overflow), 64'(v.cnt != 0 && v.base >= 14'd10240));
      end
      if (write) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 64'(address), 64'h3fff_ffff);
        end else begin
          exp_w = sb.pop_front();
          chk("wr_addr", 64'(address), 64'(exp_w.a));
          chk("wr_data", 64'(writedata), 64'(exp_w.d));
          chk("wr_be", 64'(byteenable), 64'(exp_w.e));
          chk("wr_cs", 64'(chipselect), 64'd1);
        end
        last_wr = c;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = c;
        chk("done_busy", 64'(busy), 64'd0);
      end
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = v.b0 + acc[7:0];
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0;
    chk("done_seen", 64'(got_done), 64'd1);
    chk("done_cycle", 64'(done_cyc), 64'((v.nw > 0) ? last_wr + 1 : 1));
    chk("bytes_accepted", 64'(acc), 64'(v.nacc));
    chk("overflow", 64'(overflow), 64'(v.ovf));
    chk("writes_left", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
    chk("done_one_cycle", 64'({done, busy}), 64'd0);
  endtask

  initial begin
    vecs[0] = '{14'h0010, 16'd8, 8'h01, 2, 14'h0010, 32'h04030201, 4'hF, 14'h0011, 32'h08070605, 4'hF, 1'b0, 8};
    vecs[1] = '{14'h0000, 16'd6, 8'hAA, 2, 14'h0000, 32'hADACABAA, 4'hF, 14'h0001, 32'h0000AFAE, 4'h3, 1'b0, 6};
    vecs[2] = '{14'h0005, 16'd0, 8'h00, 0, 14'h0, 32'h0, 4'h0, 14'h0, 32'h0, 4'h0, 1'b0, 0};
    vecs[3] = '{14'd10239, 16'd8, 8'h01, 1, 14'd10239, 32'h04030201, 4'hF, 14'h0, 32'h0, 4'h0, 1'b1, 4};
    vecs[4] = '{14'd10240, 16'd4, 8'h00, 0, 14'h0, 32'h0, 4'h0, 14'h0, 32'h0, 4'h0, 1'b1, 0};
    vecs[5] = '{14'h0100, 16'd1, 8'h5A, 1, 14'h0100, 32'h0000005A, 4'h1, 14'h0, 32'h0, 4'h0, 1'b0, 1};
    vecs[6] = '{14'd10238, 16'd8, 8'h11, 2, 14'd10238, 32'h14131211, 4'hF, 14'd10239, 32'h18171615, 4'hF, 1'b0, 8};
    vrst    = '{14'h0020, 16'd4, 8'hC1, 1, 14'h0020, 32'hC4C3C2C1, 4'hF, 14'h0, 32'h0, 4'h0, 1'b0, 4};

    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    byte_count = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    #12;
    chk("reset_outputs",
        64'({in_ready, address, byteenable, chipselect, write, writedata, busy, done, overflow, clken}),
        64'({1'b0, 14'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run(vecs[i], 1'b0, 1'b0);

    // Same data as the first transfer, under random backpressure and stray starts.
    run(vecs[0], 1'b1, 1'b1);

    @(negedge clk);
    start      = 1'b1;
    base_addr  = 14'h0040;
    byte_count = 16'd4;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h51;
    @(negedge clk);
    in_data = 8'h52;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    chk("mid_be", 64'(byteenable), 64'h3);
    chk("mid_no_write", 64'(write), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        64'({in_ready, address, byteenable, chipselect, write, writedata, busy, done, overflow, clken}),
        64'({1'b0, 14'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
    @(posedge clk);
    #1;
    chk("reset_hold_no_write", 64'({write, chipselect, busy}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run(vrst, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
